aes_inv_mix_columns_seq: RTL

AES_INV_MIX_COLUMNS_SEQ -- requirements
Module: aes_inv_mix_columns_seq

---
 rtl/aes_inv_mix_columns_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/aes_inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: one shared column datapath, one column per cycle.
// Optional macro AES_IMC_BYPASS_EN adds an inBypass input that passes the state through.
module aes_inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] inData,
`ifdef AES_IMC_BYPASS_EN
  input  logic         inBypass,
`endif
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outData
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StProc = 2'd1,
    StDone = 2'd2
  } st_e;

  st_e          st_q, st_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] state_q, state_d;
  logic [31:0]  col_in, col_xf, col_new;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {0E*a, 0B*a, 0D*a, 09*a} built from doubling chains only.
  function automatic logic [31:0] inv_mul(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  always_comb begin
    col_in = 32'h0;
    unique case (col_q)
      2'd0: col_in = state_q[127:96];
      2'd1: col_in = state_q[95:64];
      2'd2: col_in = state_q[63:32];
      2'd3: col_in = state_q[31:0];
      default: col_in = 32'h0;
    endcase
  end

  // Shared column datapath; m<r> = {0E,0B,0D,09} multiples of row-r input byte.
  logic [31:0] m0, m1, m2, m3;
  always_comb begin
    m0 = inv_mul(col_in[31:24]);
    m1 = inv_mul(col_in[23:16]);
    m2 = inv_mul(col_in[15:8]);
    m3 = inv_mul(col_in[7:0]);
    col_xf[31:24] = m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0];
    col_xf[23:16] = m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8];
    col_xf[15:8]  = m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16];
    col_xf[7:0]   = m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24];
  end

`ifdef AES_IMC_BYPASS_EN
  logic bypass_q, bypass_d;
  assign col_new = bypass_q ? col_in : col_xf;
`else
  assign col_new = col_xf;
`endif

  always_comb begin
    st_d    = st_q;
    col_d   = col_q;
    state_d = state_q;
`ifdef AES_IMC_BYPASS_EN
    bypass_d = bypass_q;
`endif
    case (st_q)
      StIdle: begin
        if (inValid) begin
          state_d = inData;
          col_d   = 2'd0;
          st_d    = StProc;
`ifdef AES_IMC_BYPASS_EN
          bypass_d = inBypass;
`endif
        end
      end
      StProc: begin
        unique case (col_q)
          2'd0: state_d[127:96] = col_new;
          2'd1: state_d[95:64]  = col_new;
          2'd2: state_d[63:32]  = col_new;
          2'd3: state_d[31:0]   = col_new;
          default: ;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) st_d = StDone;
      end
      StDone: begin
        if (outReady) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      col_q   <= 2'd0;
      state_q <= 128'h0;
`ifdef AES_IMC_BYPASS_EN
      bypass_q <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      col_q   <= col_d;
      state_q <= state_d;
`ifdef AES_IMC_BYPASS_EN
      bypass_q <= bypass_d;
`endif
    end
  end

  assign inReady  = (st_q == StIdle);
  assign outValid = (st_q == StDone);
  assign outData  = state_q;

endmodule
